// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder: FSM states, default
// counter width and the forward Gray-order successor.
package quad_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Forward order 00 -> 01 -> 11 -> 10 -> 00
   function automatic logic [1:0] gray_fwd(input logic [1:0] p);
      logic [1:0] n;
      case (p)
         2'b00:   n = 2'b01;
         2'b01:   n = 2'b11;
         2'b11:   n = 2'b10;
         default: n = 2'b00;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser into the clk domain, synchronous active-low
// reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic s1_q, s2_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: synchronises A/B, decodes Gray transitions into
// up/down steps and accumulates a wrapping position count with error flags.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             enable,
   input  logic             clear,
   output logic [WIDTH-1:0] count_out,
   output logic             dir_out,
   output logic             step_pulse,
   output logic             err_pulse,
   output logic             err_sticky
);

   logic             a_s, b_s;
   logic [1:0]       pair;
   state_t           state_q;
   logic             sync_cnt_q;
   logic [1:0]       prev_q;
   logic [WIDTH-1:0] count_q;
   logic             dir_q, step_q, err_q, sticky_q;
   logic             is_up, is_dn, is_err;

   sync_2ff u_sync_a (.clk(clk), .rst(rst), .d_i(a_in), .q_o(a_s));
   sync_2ff u_sync_b (.clk(clk), .rst(rst), .d_i(b_in), .q_o(b_s));

   assign pair   = {a_s, b_s};
   assign is_up  = (pair == gray_fwd(prev_q));
   assign is_dn  = (prev_q == gray_fwd(pair));
   assign is_err = (pair == ~prev_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= SYNC;
         sync_cnt_q <= 1'b0;
         prev_q     <= 2'b00;
         count_q    <= '0;
         dir_q      <= 1'b1;
         step_q     <= 1'b0;
         err_q      <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         step_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            SYNC: begin
               sync_cnt_q <= ~sync_cnt_q;
               if (sync_cnt_q) state_q <= LOAD;
            end
            LOAD: begin
               prev_q  <= pair;
               state_q <= RUN;
            end
            RUN: begin
               prev_q <= pair;
               // clear wins over any step or error decoded this cycle
               if (!clear) begin
                  if (is_up && enable) begin
                     count_q <= count_q + WIDTH'(1);
                     dir_q   <= 1'b1;
                     step_q  <= 1'b1;
                  end else if (is_dn && enable) begin
                     count_q <= count_q - WIDTH'(1);
                     dir_q   <= 1'b0;
                     step_q  <= 1'b1;
                  end else if (is_err) begin
                     err_q    <= 1'b1;
                     sticky_q <= 1'b1;
                  end
               end
            end
            default: state_q <= SYNC;
         endcase
         if (clear) begin
            count_q  <= '0;
            sticky_q <= 1'b0;
         end
      end
   end

   assign count_out  = count_q;
   assign dir_out    = dir_q;
   assign step_pulse = step_q;
   assign err_pulse  = err_q;
   assign err_sticky = sticky_q;

endmodule
